control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardwired control unit that drives the datapath's register-transfer strobes.
//  It sequences fetch (T0-T2) and R-format ALU execute (T3-T6) from the IR contents.
//  It replaces the hand-driven stimulus used to exercise the datapath. It sits directly
//  upstream of the datapath: its outputs wire 1:1 to the datapath control inputs, and the
//  IR is fed back from the datapath.
// PARAMETERS
//  OPW    5  opcode / ALU OP width (IR[31:27])
//  RSELW  4  register-field width; RSELW=4 gives 16 GPRs R0..R15
// PORTS
//  Clock     in   1   system clock; all state changes on rising edge
//  Clear     in   1   asynchronous, active-low reset
//  IR        in   32  current instruction register value from datapath
//  Mem_ready in   1   memory read complete; sampled in T1
//  Rin       out  16  one-hot GPR load strobes {R15in..R0in}
//  Rout      out  16  one-hot GPR bus-drive strobes {R15out..R0out}
//  PCin, PCout, IRin, MARin, MDRin, MDRout, Yin        out 1  datapath strobes
//  ZHighin, ZLowin, ZHighout, ZLowout, HIin, LOin      out 1  datapath strobes
//  Read, IncPC  out 1     memory read request; ALU PC-increment select
//  OP           out OPW   ALU operation code
//  Run          out 1     1 while sequencing, 0 in reset/halt
// BEHAVIOUR
//  - Clear=0 (any time, async): state<=RST; all outputs 0, Run=0; mid-instruction work is abandoned.
//  - Outputs are Moore-decoded from state plus IR fields ra=IR[26:23], rb=IR[22:19], rc=IR[18:15].
//    Each output is valid for the whole cycle; the datapath captures it on the next edge.
//  - RST: first edge with Clear=1 -> T0.
//  - T0: PCout, MARin, IncPC, ZLowin -> T1.
//  - T1: Read, MDRin every cycle. Holds in T1 while Mem_ready=0.
//    PCin=1 only in the cycle Mem_ready=1 (Mealy term). -> T2 on Mem_ready=1.
//  - T2: MDRout, IRin -> T3 for ALU opcodes; nop -> T0; halt -> HALT; illegal -> T0 (nop).
//  - T3: Rout[rb], Yin.
//  - T4: OP=opcode and ZLowin.
//    Binary ops: Rout[rc]. Unary ops (neg, not): Rout[rb].
//    mul/div additionally assert ZHighin.
//  - T5: ZLowout with Rin[ra] -> T0. For mul/div: ZLowout with LOin -> T6.
//  - T6 (mul/div only): ZHighout, HIin -> T0.
//  - HALT: all strobes 0, Run=0; exits only via Clear.
//  - Opcodes (OP passes opcode unchanged):
//    add 00011, sub 00100, and 00101, or 00110, shr 00111, shra 01000, shl 01001,
//    ror 01010, rol 01011, mul 01111, div 10000, neg 10001, not 10010, nop 11010, halt 11011.
//  - Rin/Rout are exactly one-hot or zero; never two GPR strobes at once. R0 is writable.
//  - OP=0 outside T4. IR is sampled combinationally each state; it is stable after T2.
//  - Latency: ALU op = 6 cycles + (Mem_ready wait); mul/div = 7 cycles + wait.
// CONFIGURATION
//  CU_STOP_EN: defined -> extra input Stop (1b). If Stop=1 when leaving T5, T6 or T2(nop),
//    go to PAUSE (Run=0, strobes 0) instead of T0. Resume to T0 on the first edge with Stop=0.
//    Stop is ignored mid-instruction.
//  Undefined -> no Stop port and no PAUSE state; behaviour otherwise identical.
// STRUCTURE
//  - Shared package/include cpu_defs: opcode localparams, state encodings (RST,T0..T6,HALT,PAUSE),
//    IR field bit positions.
//  - Sub-module reg_sel_decoder: RSELW-to-16 one-hot decoder with enable.
//    Instantiated twice: Rin from ra, Rout from rb/rc mux.
// TESTING
//  1. Clear=0 then 1 -> all outputs 0 during reset; first edge enters T0 with PCout=MARin=IncPC=ZLowin=1.
//  2. IR=0x489A8000 (shl r1,r3,r5), Mem_ready=1 ->
//     T3 Rout=0x0008,Yin; T4 Rout=0x0020, OP=01001, ZLowin; T5 ZLowout, Rin=0x0002; then T0.
//  3. Mem_ready held 0 for 3 cycles in T1 -> Read=MDRin=1 for 4 cycles; PCin pulses only on the last.
//  4. IR=0x78B80000 (mul, rb=7, rc=0) ->
//     T4 Rout=0x0001, ZHighin=ZLowin=1, OP=01111; T5 LOin; T6 ZHighout, HIin; Rin stays 0 throughout.
//  5. IR opcode 11011 (halt) -> after T2, Run=0 and all strobes 0 for 20 cycles; Clear pulse restarts at T0.
//  6. Clear asserted during T4 -> outputs 0 asynchronously, before the next edge; restart from T0.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared definitions for the hardwired control sequencer: opcodes, IR field
// positions, state encoding and opcode classification helpers.
package cpu_defs;

    localparam int CU_OPW   = 5;
    localparam int CU_RSELW = 4;

    localparam int OP_LSB = 27;
    localparam int RA_LSB = 23;
    localparam int RB_LSB = 19;
    localparam int RC_LSB = 15;

    localparam logic [CU_OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [CU_OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [CU_OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [CU_OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [CU_OPW-1:0] OP_SHR  = 5'b00111;
    localparam logic [CU_OPW-1:0] OP_SHRA = 5'b01000;
    localparam logic [CU_OPW-1:0] OP_SHL  = 5'b01001;
    localparam logic [CU_OPW-1:0] OP_ROR  = 5'b01010;
    localparam logic [CU_OPW-1:0] OP_ROL  = 5'b01011;
    localparam logic [CU_OPW-1:0] OP_MUL  = 5'b01111;
    localparam logic [CU_OPW-1:0] OP_DIV  = 5'b10000;
    localparam logic [CU_OPW-1:0] OP_NEG  = 5'b10001;
    localparam logic [CU_OPW-1:0] OP_NOT  = 5'b10010;
    localparam logic [CU_OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [CU_OPW-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_RST   = 4'd0,
        ST_T0    = 4'd1,
        ST_T1    = 4'd2,
        ST_T2    = 4'd3,
        ST_T3    = 4'd4,
        ST_T4    = 4'd5,
        ST_T5    = 4'd6,
        ST_T6    = 4'd7,
        ST_HALT  = 4'd8,
        ST_PAUSE = 4'd9
    } state_e;

    function automatic logic is_muldiv(input logic [CU_OPW-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_unary(input logic [CU_OPW-1:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    function automatic logic is_alu(input logic [CU_OPW-1:0] op);
        logic r;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
            OP_ROR, OP_ROL, OP_MUL, OP_DIV, OP_NEG, OP_NOT: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// Register-select decoder: turns a GPR index into a one-hot strobe vector,
// all zeros when disabled.
module reg_sel_decoder #(
    parameter int SELW = 4,
    parameter int OUTW = 16
) (
    input  logic            en,
    input  logic [SELW-1:0] sel,
    output logic [OUTW-1:0] onehot
);

    // One-hot decode gated by enable
    always_comb begin
        onehot = {OUTW{1'b0}};
        if (en) begin
            onehot[sel] = 1'b1;
        end else begin
            onehot = {OUTW{1'b0}};
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit sequencing fetch (T0-T2) and R-format ALU execute (T3-T6).
// Optional CU_STOP_EN adds a Stop input and a PAUSE state between instructions.
module control_sequencer
    import cpu_defs::*;
#(
    parameter int OPW   = CU_OPW,
    parameter int RSELW = CU_RSELW
) (
    input  logic                  Clock,
    input  logic                  Clear,
    input  logic [31:0]           IR,
    input  logic                  Mem_ready,
`ifdef CU_STOP_EN
    input  logic                  Stop,
`endif
    output logic [(1<<RSELW)-1:0] Rin,
    output logic [(1<<RSELW)-1:0] Rout,
    output logic                  PCin,
    output logic                  PCout,
    output logic                  IRin,
    output logic                  MARin,
    output logic                  MDRin,
    output logic                  MDRout,
    output logic                  Yin,
    output logic                  ZHighin,
    output logic                  ZLowin,
    output logic                  ZHighout,
    output logic                  ZLowout,
    output logic                  HIin,
    output logic                  LOin,
    output logic                  Read,
    output logic                  IncPC,
    output logic [OPW-1:0]        OP,
    output logic                  Run
);

    localparam int NGPR = 1 << RSELW;

    state_e             state_q, state_d, done_next_s;
    logic [OPW-1:0]     op_s;
    logic [RSELW-1:0]   ra_s, rb_s, rc_s, rout_sel_s;
    logic               rin_en_s, rout_en_s, md_s;
    logic               unused_ir_s;

    assign op_s        = IR[OP_LSB +: OPW];
    assign ra_s        = IR[RA_LSB +: RSELW];
    assign rb_s        = IR[RB_LSB +: RSELW];
    assign rc_s        = IR[RC_LSB +: RSELW];
    assign md_s        = is_muldiv(op_s);
    assign unused_ir_s = ^IR[14:0];

    // Where an instruction goes once it completes: straight to the next fetch, or park
`ifdef CU_STOP_EN
    assign done_next_s = Stop ? ST_PAUSE : ST_T0;
`else
    assign done_next_s = ST_T0;
`endif

    // State register; Clear abandons any in-flight instruction immediately
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST: state_d = ST_T0;
            ST_T0:  state_d = ST_T1;
            ST_T1:  state_d = Mem_ready ? ST_T2 : ST_T1;
            ST_T2: begin
                if (op_s == OP_HALT) begin
                    state_d = ST_HALT;
                end else if (is_alu(op_s)) begin
                    state_d = ST_T3;
                end else begin
                    state_d = done_next_s;
                end
            end
            ST_T3:   state_d = ST_T4;
            ST_T4:   state_d = ST_T5;
            ST_T5:   state_d = md_s ? ST_T6 : done_next_s;
            ST_T6:   state_d = done_next_s;
            ST_HALT: state_d = ST_HALT;
`ifdef CU_STOP_EN
            ST_PAUSE: state_d = Stop ? ST_PAUSE : ST_T0;
`else
            ST_PAUSE: state_d = ST_T0;
`endif
            default: state_d = ST_RST;
        endcase
    end

    // Strobe decode from state and IR fields; PCin also looks at Mem_ready
    always_comb begin
        PCin = 1'b0;  PCout = 1'b0;  IRin = 1'b0;    MARin = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; Yin = 1'b0;     ZHighin = 1'b0;
        ZLowin = 1'b0; ZHighout = 1'b0; ZLowout = 1'b0; HIin = 1'b0;
        LOin = 1'b0;  Read = 1'b0;   IncPC = 1'b0;   OP = {OPW{1'b0}};
        Run = 1'b0;   rin_en_s = 1'b0; rout_en_s = 1'b0; rout_sel_s = rb_s;
        case (state_q)
            ST_T0: begin
                Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowin = 1'b1;
            end
            ST_T1: begin
                Run = 1'b1; Read = 1'b1; MDRin = 1'b1; PCin = Mem_ready;
            end
            ST_T2: begin
                Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
            end
            ST_T3: begin
                Run = 1'b1; rout_en_s = 1'b1; rout_sel_s = rb_s; Yin = 1'b1;
            end
            ST_T4: begin
                Run = 1'b1; rout_en_s = 1'b1;
                rout_sel_s = is_unary(op_s) ? rb_s : rc_s;
                OP = op_s; ZLowin = 1'b1; ZHighin = md_s;
            end
            ST_T5: begin
                Run = 1'b1; ZLowout = 1'b1;
                if (md_s) begin
                    LOin = 1'b1;
                end else begin
                    rin_en_s = 1'b1;
                end
            end
            ST_T6: begin
                Run = 1'b1; ZHighout = 1'b1; HIin = 1'b1;
            end
            default: begin
                Run = 1'b0;
            end
        endcase
    end

    reg_sel_decoder #(.SELW(RSELW), .OUTW(NGPR)) u_rin_dec (
        .en     (rin_en_s),
        .sel    (ra_s),
        .onehot (Rin)
    );

    reg_sel_decoder #(.SELW(RSELW), .OUTW(NGPR)) u_rout_dec (
        .en     (rout_en_s),
        .sel    (rout_sel_s),
        .onehot (Rout)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: an instruction-level model builds
// the expected per-cycle strobe trace for each (random) instruction.
module tb_control_sequencer;

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic pcin, pcout, irin, marin, mdrin, mdrout, yin, zhighin, zlowin;
        logic zhighout, zlowout, hiin, loin, read, incpc;
        logic [4:0] op;
        logic run;
    } outs_t;

    logic        Clock = 1'b0;
    logic        Clear = 1'b0;
    logic [31:0] IR = 32'h0;
    logic        Mem_ready = 1'b0;
`ifdef CU_STOP_EN
    logic        Stop = 1'b0;
`endif
    logic [15:0] Rin, Rout;
    logic PCin, PCout, IRin, MARin, MDRin, MDRout, Yin, ZHighin, ZLowin;
    logic ZHighout, ZLowout, HIin, LOin, Read, IncPC, Run;
    logic [4:0]  OP;
    outs_t       obs_s;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [4:0] alu_ops [13] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                 5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01111,
                                 5'b10000, 5'b10001, 5'b10010};
    localparam logic [4:0] NOP_OP  = 5'b11010;
    localparam logic [4:0] HALT_OP = 5'b11011;

    control_sequencer dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .Mem_ready(Mem_ready),
`ifdef CU_STOP_EN
        .Stop(Stop),
`endif
        .Rin(Rin), .Rout(Rout), .PCin(PCin), .PCout(PCout), .IRin(IRin),
        .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Yin(Yin),
        .ZHighin(ZHighin), .ZLowin(ZLowin), .ZHighout(ZHighout), .ZLowout(ZLowout),
        .HIin(HIin), .LOin(LOin), .Read(Read), .IncPC(IncPC), .OP(OP), .Run(Run)
    );

    always #5 Clock = ~Clock;

    assign obs_s = {Rin, Rout, PCin, PCout, IRin, MARin, MDRin, MDRout, Yin, ZHighin,
                    ZLowin, ZHighout, ZLowout, HIin, LOin, Read, IncPC, OP, Run};

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_alu(input logic [4:0] op);
        foreach (alu_ops[i]) if (alu_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic outs_t running();
        outs_t e = '0;
        e.run = 1'b1;
        return e;
    endfunction

    // Executes one instruction against its expected trace; stop_at>=0 leaves early
    // (at posedge+1 of that trace step) without checking it.
    task automatic run_instr(input logic [31:0] ir, input int waits, input int n_halt,
                             input int stop_at);
        outs_t tq[$];
        bit    mq[$];
        outs_t e;
        logic [4:0] op;
        int ra, rb, rc;
        bit md, un;
        op = ir[31:27];
        ra = int'(ir[26:23]); rb = int'(ir[22:19]); rc = int'(ir[18:15]);
        md = (op == 5'b01111) || (op == 5'b10000);
        un = (op == 5'b10001) || (op == 5'b10010);

        e = running(); e.pcout = 1'b1; e.marin = 1'b1; e.incpc = 1'b1; e.zlowin = 1'b1;
        tq.push_back(e); mq.push_back(1'($urandom_range(0, 1)));
        for (int w = 0; w < waits; w++) begin
            e = running(); e.read = 1'b1; e.mdrin = 1'b1;
            tq.push_back(e); mq.push_back(1'b0);
        end
        e = running(); e.read = 1'b1; e.mdrin = 1'b1; e.pcin = 1'b1;
        tq.push_back(e); mq.push_back(1'b1);
        e = running(); e.mdrout = 1'b1; e.irin = 1'b1;
        tq.push_back(e); mq.push_back(1'($urandom_range(0, 1)));
        if (in_alu(op)) begin
            e = running(); e.rout = 16'h0001 << rb; e.yin = 1'b1;
            tq.push_back(e); mq.push_back(1'($urandom_range(0, 1)));
            e = running(); e.rout = 16'h0001 << (un ? rb : rc); e.op = op;
            e.zlowin = 1'b1; e.zhighin = md;
            tq.push_back(e); mq.push_back(1'($urandom_range(0, 1)));
            e = running(); e.zlowout = 1'b1;
            if (md) e.loin = 1'b1; else e.rin = 16'h0001 << ra;
            tq.push_back(e); mq.push_back(1'($urandom_range(0, 1)));
            if (md) begin
                e = running(); e.zhighout = 1'b1; e.hiin = 1'b1;
                tq.push_back(e); mq.push_back(1'($urandom_range(0, 1)));
            end
        end else if (op == HALT_OP) begin
            for (int h = 0; h < n_halt; h++) begin
                tq.push_back('0); mq.push_back(1'($urandom_range(0, 1)));
            end
        end

        IR = ir;
        for (int i = 0; i < tq.size(); i++) begin
            if (stop_at >= 0 && i == stop_at) return;
            Mem_ready = mq[i];
            @(negedge Clock);
            check_val($sformatf("ir%08h_c%0d", ir, i), 64'(obs_s), 64'(tq[i]));
            @(posedge Clock);
            #1;
        end
    endtask

    // Asserts Clear mid-cycle, checks outputs drop before the next edge, releases it
    task automatic clear_pulse(input string tag);
        #1 Clear = 1'b0;
        #1 check_val(tag, 64'(obs_s), 64'h0);
        @(negedge Clock);
        check_val({tag, "_held"}, 64'(obs_s), 64'h0);
        Clear = 1'b1;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        logic [31:0] rnd;
        logic [4:0]  op;
        int          pick;

        Clear = 1'b0;
        repeat (3) begin
            @(negedge Clock);
            check_val("reset", 64'(obs_s), 64'h0);
        end
        Clear = 1'b1;
        @(posedge Clock);
        #1;

        run_instr(32'h489A8000, 0, 0, -1);   // shl r1,r3,r5
        run_instr(32'h78B80000, 0, 0, -1);   // mul rb=7 rc=0
        run_instr(32'h489A8000, 3, 0, -1);   // three memory wait states
        run_instr({NOP_OP, 27'h1234567}, 1, 0, -1);

        for (int n = 0; n < 40; n++) begin
            rnd  = $urandom();
            pick = int'($urandom_range(0, 15));
            if (pick < 13) begin
                op = alu_ops[pick];
            end else if (pick == 13) begin
                op = NOP_OP;
            end else begin
                op = 5'($urandom_range(0, 31));
                if (op == HALT_OP) op = NOP_OP;
            end
            run_instr({op, rnd[26:0]}, int'($urandom_range(0, 3)), 0, -1);
        end

        // Clear while in T4 of an add
        run_instr(32'h18A30000, 0, 0, 4);
        @(negedge Clock);
        check_val("t4_op", 64'(OP), 64'(5'b00011));
        clear_pulse("clr_t4");
        run_instr(32'h80C48000, 2, 0, -1);   // div after restart

        // Halt, then a Clear pulse restarts fetch
        run_instr({HALT_OP, 27'h0}, 1, 20, -1);
        clear_pulse("clr_halt");
        run_instr(32'h489A8000, 0, 0, -1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
